arb_rr: RTL

ARB_RR -- requirements
Module: arb_rr

---
 rtl/arb_pkg.sv | 15 +
 rtl/oht2bin.sv | 37 +++
 rtl/arb_rr.sv | 100 ++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types for the round-robin arbiter: FSM state encoding and
// a small helper used to advance the rotating priority pointer.
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Rotating pointer increment with wrap at an arbitrary (non power-of-2) modulus.
    function automatic int unsigned ptr_inc(input int unsigned cur, input int unsigned modulus);
        return (cur >= modulus - 1) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/oht2bin.sv
// One-hot to binary encoder. IMPLEMENTATION 0 is an OR-tree per output bit,
// any other value is a priority loop (lowest set bit wins on bad input).
module oht2bin #(
    parameter  int WIDTH          = 4,
    parameter  int IMPLEMENTATION = 0,
    localparam int WIDTH_LOG      = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]     oht,
    output logic [WIDTH_LOG-1:0] bin,
    output logic                 vld
);

    assign vld = |oht;

    generate
        if (IMPLEMENTATION == 0) begin : g_or_tree
            for (genvar b = 0; b < WIDTH_LOG; b++) begin : g_bit
                logic [WIDTH-1:0] mask;
                always_comb begin
                    mask = '0;
                    for (int i = 0; i < WIDTH; i++) begin
                        mask[i] = i[b];
                    end
                end
                assign bin[b] = |(oht & mask);
            end
        end else begin : g_prio
            always_comb begin
                bin = '0;
                for (int i = WIDTH - 1; i >= 0; i--) begin
                    if (oht[i]) bin = WIDTH_LOG'(i);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/arb_rr.sv
// Round-robin arbiter holding a one-hot grant until a last-beat handshake;
// re-arbitrates in the completion cycle so back-to-back grants have no bubble.
module arb_rr
    import arb_pkg::*;
#(
    parameter  int WIDTH          = 4,
    parameter  int IMPLEMENTATION = 0,
    localparam int WIDTH_LOG      = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     req,
    input  logic                 rdy,
    input  logic                 lst,
    output logic [WIDTH-1:0]     gnt,
    output logic [WIDTH_LOG-1:0] idx,
    output logic                 vld
);

    arb_state_e           state, state_nxt;
    logic [WIDTH_LOG-1:0] ptr, ptr_nxt, ptr_done, ptr_arb;
    logic [WIDTH-1:0]     gnt_nxt, win_oh;
    logic [WIDTH_LOG:0]   pos;
    logic                 found, done, enc_vld;

    oht2bin #(
        .WIDTH          (WIDTH),
        .IMPLEMENTATION (IMPLEMENTATION)
    ) u_enc (
        .oht (gnt),
        .bin (idx),
        .vld (enc_vld)
    );

    assign vld  = (state == BUSY);
    assign done = (state == BUSY) && rdy && lst;

    // The finishing winner drops to lowest priority before the same-cycle search.
    assign ptr_done = WIDTH_LOG'(ptr_inc(int'(idx), WIDTH));
    assign ptr_arb  = (state == BUSY) ? ptr_done : ptr;

    always_comb begin
        win_oh = '0;
        found  = 1'b0;
        pos    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pos = {1'b0, ptr_arb} + (WIDTH_LOG+1)'(i);
            if (pos >= (WIDTH_LOG+1)'(WIDTH)) pos = pos - (WIDTH_LOG+1)'(WIDTH);
            if (!found && req[pos[WIDTH_LOG-1:0]]) begin
                found                     = 1'b1;
                win_oh[pos[WIDTH_LOG-1:0]] = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = BUSY;
                    gnt_nxt   = win_oh;
                end
            end
            BUSY: begin
                if (done) begin
                    ptr_nxt   = ptr_done;
                    gnt_nxt   = win_oh;
                    state_nxt = found ? BUSY : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            gnt   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            gnt   <= gnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(gnt));
            assert (enc_vld == vld);
        end
    end

endmodule
